i2s_frame_sched_t: RTL and testbench
====================================

# i2s_frame_sched_t

Stereo frame scheduler for the I2S DAC path (PCM5102A). It accepts left/right sample pairs from the audio core over a valid/ready handshake and buffers them in a small FIFO. Each pair is launched atomically at a frame boundary, so L and R always come from the same sample instant, with no inter-channel phase skew. It generates SCK/BCK/LCK/DIN directly, and reports underruns when the producer fails to keep up.

## Interface
- FIFO_DEPTH, 2: stereo frames buffered; power of two, ≥2.
- CLK  in  1  12 MHz system clock; also drives SCK.
- RST  in  1  synchronous, active-high reset.
- IN_L  in  16  left sample, two's complement.
- IN_R  in  16  right sample, two's complement.
- IN_VALID  in  1  producer offers IN_L/IN_R.
- IN_READY  out  1  FIFO can accept; transfer when IN_VALID && IN_READY at posedge CLK.
- MUTE  in  1  force zero data; clocks keep running.
- SCK  out  1  = CLK.
- BCK  out  1  CLK/4 (3 MHz).
- LCK  out  1  CLK/256 (46875 Hz); low = left, high = right.
- DIN  out  1  serial data, MSB first.
- FRAME  out  1  one-cycle pulse when a frame is launched (FIFO pop or underrun).
- UNDERRUN  out  1  one-cycle pulse, frame launched with FIFO empty.
- UNDERRUN_CNT  out  8  saturating underrun count.

## Operation
- Free-running 8-bit counter `cnt`, +1 every CLK, wraps 255→0. BCK = cnt[1], LCK = cnt[7].
- Frame launch at cnt==255:
  - FIFO non-empty: pop into hold_L/hold_R; pulse FRAME.
  - FIFO empty: pulse FRAME and UNDERRUN; increment UNDERRUN_CNT, saturating at 255.
- Shift register `sh` (16b), DIN = sh[15]. It updates only when cnt[1:0]==0 (BCK falling edge):
  - cnt[6:2]==1: load hold_L if cnt[7]==0, else hold_R. Load zero instead if MUTE.
  - otherwise: shift left, filling with 0.
- MSB appears one BCK after the LCK edge (I2S format). 16 data bits occupy slots 1–16 of each 32-BCK half-frame; the remaining slots are 0.
- MUTE is sampled at each shift load only; a mid-channel change affects the next channel word.
- FIFO: IN_READY = !full && !RST.
  - A push and a pop in the same cycle are both performed.
  - There is no bypass: a push at cnt==255 into an empty FIFO is not visible to that launch. That launch underruns; the pushed frame launches next frame.
- RST: cnt, sh, hold_L/R, FIFO pointers, and UNDERRUN_CNT clear; an in-flight frame is abandoned.

## Timing
- Reset values: BCK=0, LCK=0, DIN=0, FRAME=0, UNDERRUN=0, UNDERRUN_CNT=0, IN_READY=0 while RST, 1 on the first cycle after.
- First cycle after RST release has cnt=0.
- First launch at cnt==255, i.e. 256 cycles after release. A pair pushed before then is loaded into sh at cnt==4 of the next frame; its MSB is on DIN from that cycle.
- Push-to-DIN latency for an empty-FIFO push: between 5 and 260 cycles plus queued frames × 256.
- Right word loads at cnt==132.
- Sustained throughput: one pair per 256 cycles. With FIFO full, IN_READY reasserts the cycle after a launch pop.
- FRAME and UNDERRUN are registered and high during the cycle where cnt==0.

## Configuration
- I2S_UNDERRUN_HOLD_EN defined: on underrun, hold_L/hold_R keep their previous values, so the last frame repeats.
- I2S_UNDERRUN_HOLD_EN undefined: on underrun, hold_L/hold_R are cleared to 0, giving silence.
- UNDERRUN and UNDERRUN_CNT behave identically in both builds.

## Structure
- Package i2s_pkg:
  - FRAME_CLKS=256, LAUNCH_CNT=8'd255, LOAD_SLOT=5'd1.
  - typedef stereo_frame_t = struct {logic [15:0] l, r}.
- Sub-module sample_fifo_t: synchronous FIFO of stereo_frame_t, FIFO_DEPTH entries. Ports: push/pop/full/empty and count.
- Counter, hold registers, shift register and status logic stay in i2s_frame_sched_t.

## Test plan
- Reset: hold RST 3 cycles → all outputs at reset values, IN_READY=0. IN_READY=1 on the cycle after release; DIN=0 throughout the first frame.
- Single frame: push L=16'hA5C3, R=16'h0F01 at cycle 10 → DIN serialises A5C3 MSB-first from cnt==4 of frame 2 (LCK=0), then 0F01 from cnt==132 (LCK=1). One FRAME pulse, no UNDERRUN.
- Backpressure: hold IN_VALID=1 with incrementing pairs → after 2 accepts IN_READY=0; exactly one accept per 256 cycles thereafter; no pair lost or duplicated.
- Underrun: stop pushing after pair 16'h1234/16'h5678 → next frame raises UNDERRUN and UNDERRUN_CNT=1. DIN repeats 1234/5678 with I2S_UNDERRUN_HOLD_EN, and gives all zeros without it.
- Saturation and mute: 300 consecutive underruns → UNDERRUN_CNT=255. With MUTE=1 and FIFO fed 16'h7FFF, DIN=0 while FRAME still pulses.
- Reset mid-frame: assert RST at cnt==70 with FIFO holding 2 frames → FIFO empty, cnt=0 after release, and the old frames never appear on DIN.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and frame-timing constants for the I2S stereo frame scheduler.
package i2s_pkg;

  localparam int          DATA_W     = 16;
  localparam int          FRAME_CLKS = 256;
  localparam logic [7:0]  LAUNCH_CNT = 8'd255;
  localparam logic [4:0]  LOAD_SLOT  = 5'd1;

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } stereo_frame_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sample_fifo_t.sv
// Synchronous FIFO of stereo frames; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module sample_fifo_t
  import i2s_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  stereo_frame_t wr_data,
  input  logic          pop,
  output stereo_frame_t rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  stereo_frame_t mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));

endmodule

// File: rtl/i2s_frame_sched_t.sv
// I2S stereo frame scheduler: buffers L/R pairs and launches each pair atomically
// at the frame boundary. Define I2S_UNDERRUN_HOLD_EN to repeat the last frame on underrun.
module i2s_frame_sched_t
  import i2s_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic signed [DATA_W-1:0] IN_L,
  input  logic signed [DATA_W-1:0] IN_R,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic                     MUTE,
  output logic                     SCK,
  output logic                     BCK,
  output logic                     LCK,
  output logic                     DIN,
  output logic                     FRAME,
  output logic                     UNDERRUN,
  output logic [7:0]               UNDERRUN_CNT
);

  localparam int CNT_W = $clog2(FRAME_CLKS);
  localparam int FAW   = $clog2(FIFO_DEPTH);

`ifdef I2S_UNDERRUN_HOLD_EN
  localparam bit HOLD_ON_UNDERRUN = 1'b1;
`else
  localparam bit HOLD_ON_UNDERRUN = 1'b0;
`endif

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              launch;
  logic              bck_fall;
  logic              word_load;

  stereo_frame_t     fifo_wr;
  stereo_frame_t     fifo_rd;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FAW:0]      fifo_cnt;

  stereo_frame_t     hold_p1;
  logic              frame_p1;
  logic              urun_p1;
  logic [7:0]        urun_cnt;
  logic [DATA_W-1:0] sh_p2;

  assign cnt_nxt   = cnt + CNT_W'(1);
  assign launch    = (cnt == LAUNCH_CNT);
  // DIN changes on the BCK falling edge, i.e. on entry to a cnt with [1:0]==0.
  assign bck_fall  = (cnt_nxt[1:0] == 2'b00);
  assign word_load = bck_fall && (cnt_nxt[6:2] == LOAD_SLOT);

  assign fifo_wr   = '{l: IN_L, r: IN_R};
  assign IN_READY  = !fifo_full && !RST;
  assign fifo_push = IN_VALID && IN_READY;
  assign fifo_pop  = launch && !fifo_empty;

  sample_fifo_t #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (fifo_push),
    .wr_data (fifo_wr),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  // Stage p1: frame launch into the hold registers plus status pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_p1  <= '0;
      frame_p1 <= 1'b0;
      urun_p1  <= 1'b0;
      urun_cnt <= '0;
    end else begin
      frame_p1 <= launch;
      urun_p1  <= launch && fifo_empty;
      if (launch && fifo_empty) urun_cnt <= sat_inc8(urun_cnt);
      if (fifo_pop)
        hold_p1 <= fifo_rd;
      else if (launch && !HOLD_ON_UNDERRUN)
        hold_p1 <= '0;
    end
  end

  // Stage p2: per-channel word load and MSB-first serialisation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_p2 <= '0;
    end else if (bck_fall) begin
      if (word_load)
        sh_p2 <= MUTE ? '0 : (cnt_nxt[CNT_W-1] ? hold_p1.r : hold_p1.l);
      else
        sh_p2 <= {sh_p2[DATA_W-2:0], 1'b0};
    end
  end

  assign SCK          = CLK;
  assign BCK          = cnt[1];
  assign LCK          = cnt[CNT_W-1];
  assign DIN          = sh_p2[DATA_W-1];
  assign FRAME        = frame_p1;
  assign UNDERRUN     = urun_p1;
  assign UNDERRUN_CNT = urun_cnt;

  a_fifo_occupancy: assert property (@(posedge CLK) disable iff (RST)
    fifo_cnt <= (FAW+1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_i2s_frame_sched_t.sv
// Bench for i2s_frame_sched_t: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_i2s_frame_sched_t;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] IN_L, IN_R;
  logic        IN_VALID, IN_READY, MUTE;
  logic        SCK, BCK, LCK, DIN, FRAME, UNDERRUN;
  logic [7:0]  UNDERRUN_CNT;

  always #5 CLK = ~CLK;

  i2s_frame_sched_t #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .IN_L         (IN_L),
    .IN_R         (IN_R),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .MUTE         (MUTE),
    .SCK          (SCK),
    .BCK          (BCK),
    .LCK          (LCK),
    .DIN          (DIN),
    .FRAME        (FRAME),
    .UNDERRUN     (UNDERRUN),
    .UNDERRUN_CNT (UNDERRUN_CNT)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name, input int cycles);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen within %0d cycles, expected it to occur", name, cycles);
  endtask

  // Frame-level reference model: position in frame, queue of pending pairs,
  // the launched pair, and the word captured at each channel load.
  int          m_cnt;
  logic [15:0] q_l[$];
  logic [15:0] q_r[$];
  logic [15:0] cur_l, cur_r, w_l, w_r;
  bit          m_frame, m_urun;
  int          m_ucnt;
  bit          chk_en = 0;

  always @(posedge CLK) begin
    bit acc;
    if (RST) begin
      m_cnt = 0;
      q_l.delete();
      q_r.delete();
      cur_l = 0; cur_r = 0; w_l = 0; w_r = 0;
      m_frame = 0; m_urun = 0; m_ucnt = 0;
    end else begin
      acc = IN_VALID && (q_l.size() < DEPTH);
      m_frame = 0;
      m_urun  = 0;
      if (m_cnt == 255) begin
        m_frame = 1;
        if (q_l.size() > 0) begin
          cur_l = q_l.pop_front();
          cur_r = q_r.pop_front();
        end else begin
          m_urun = 1;
          if (m_ucnt < 255) m_ucnt++;
`ifndef I2S_UNDERRUN_HOLD_EN
          cur_l = 0;
          cur_r = 0;
`endif
        end
      end
      if (acc) begin
        q_l.push_back(IN_L);
        q_r.push_back(IN_R);
      end
      m_cnt = (m_cnt + 1) % 256;
      if (m_cnt == 4)   w_l = MUTE ? 16'h0 : cur_l;
      if (m_cnt == 132) w_r = MUTE ? 16'h0 : cur_r;
    end
    chk_en = 1;
  end

  // I2S slot rule: slot 0 idle, slots 1..16 carry MSB..LSB, rest zero.
  function automatic bit exp_din();
    int q, slot;
    logic [15:0] w;
    q    = m_cnt % 128;
    slot = q / 4;
    w    = (m_cnt >= 128) ? w_r : w_l;
    if (slot >= 1 && slot <= 16) return w[16 - slot];
    return 1'b0;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      check("bck",          BCK,          (m_cnt >> 1) & 1);
      check("lck",          LCK,          m_cnt >= 128);
      check("din",          DIN,          exp_din());
      check("frame",        FRAME,        m_frame);
      check("underrun",     UNDERRUN,     m_urun);
      check("underrun_cnt", UNDERRUN_CNT, m_ucnt);
      check("in_ready",     IN_READY,     !RST && (q_l.size() < DEPTH));
    end
  end

  task automatic wait_cnt(input int target);
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if (m_cnt == target) return;
    end
    timeout("wait_cnt", 600);
  endtask

  task automatic push_one(input logic [15:0] l, input logic [15:0] r);
    @(posedge CLK); #1;
    IN_L = l; IN_R = r; IN_VALID = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if (IN_READY) begin
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        return;
      end
    end
    IN_VALID = 1'b0;
    timeout("push_accept", 600);
  endtask

  task automatic capture(input int start, output logic [15:0] w);
    wait_cnt(start);
    for (int k = 0; k < 16; k++) begin
      w[15 - k] = DIN;
      if (k < 15) repeat (4) @(negedge CLK);
    end
  endtask

  task automatic wait_frame(output bit seen, output int cycles);
    seen = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge CLK);
      if (FRAME) begin
        seen   = 1;
        cycles = i;
        return;
      end
    end
    cycles = 1200;
  endtask

  logic [15:0] w;
  int          accepts;
  int          fcyc;
  bit          seen;
  logic [15:0] bp_k;

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_L = '0; IN_R = '0; MUTE = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_ready", IN_READY, 0);
    check("rst_din", DIN, 0);
    check("rst_frame_urun", {FRAME, UNDERRUN}, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("release_in_ready", IN_READY, 1);
    check("release_lck_bck", {LCK, BCK}, 0);

    // Single frame pushed at cycle 10, serialised in frame 2.
    wait_cnt(8);
    push_one(16'hA5C3, 16'h0F01);
    capture(4, w);
    check("frame2_left_word", w, 16'hA5C3);
    capture(132, w);
    check("frame2_right_word", w, 16'h0F01);
    check("frame2_no_underrun", UNDERRUN_CNT, 0);

    // Backpressure with an incrementing stream over three frames.
    wait_cnt(9);
    @(posedge CLK); #1;
    bp_k = 0;
    IN_L = 16'h1000; IN_R = 16'h2000; IN_VALID = 1'b1;
    accepts = 0;
    for (int c = 0; c < 768; c++) begin
      bit acc;
      @(negedge CLK);
      acc = IN_READY;
      if (c == 10) check("bp_ready_low_when_full", IN_READY, 0);
      if (acc) accepts++;
      @(posedge CLK); #1;
      if (acc) begin
        bp_k = bp_k + 16'd1;
        IN_L = 16'h1000 + bp_k;
        IN_R = 16'h2000 + bp_k;
      end
    end
    IN_VALID = 1'b0;
    check("bp_accept_count", accepts, 5);

    // Underrun after the last pair drains.
    push_one(16'h1234, 16'h5678);
    seen = 0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge CLK);
      if (UNDERRUN) seen = 1;
    end
    if (!seen) timeout("underrun_pulse", 1200);
    else       check("underrun_cnt_after_drain", UNDERRUN_CNT, 2);
    capture(4, w);
`ifdef I2S_UNDERRUN_HOLD_EN
    check("underrun_left_word", w, 16'h1234);
`else
    check("underrun_left_word", w, 16'h0000);
`endif
    capture(132, w);
`ifdef I2S_UNDERRUN_HOLD_EN
    check("underrun_right_word", w, 16'h5678);
`else
    check("underrun_right_word", w, 16'h0000);
`endif

    // Counter saturation over a long idle stretch.
    repeat (256 * 256) @(negedge CLK);
    check("underrun_cnt_saturated", UNDERRUN_CNT, 255);

    // Mute: frame launches normally but data is forced to zero.
    @(posedge CLK); #1;
    MUTE = 1'b1;
    push_one(16'h7FFF, 16'h7FFF);
    wait_frame(seen, fcyc);
    if (!seen) timeout("mute_frame_pulse", 1200);
    else       check("mute_frame_no_underrun", UNDERRUN, 0);
    capture(4, w);
    check("mute_left_word", w, 16'h0000);
    capture(132, w);
    check("mute_right_word", w, 16'h0000);
    @(posedge CLK); #1;
    MUTE = 1'b0;

    // Reset mid-frame with two frames queued.
    wait_cnt(60);
    push_one(16'hAAAA, 16'h5555);
    push_one(16'hCCCC, 16'h3333);
    wait_cnt(69);
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_fifo_empty_ready", IN_READY, 1);
    wait_frame(seen, fcyc);
    if (!seen) timeout("post_rst_frame", 1200);
    else begin
      check("post_rst_first_launch_latency", fcyc, 255);
      check("post_rst_launch_underruns", UNDERRUN, 1);
    end
    capture(4, w);
    check("post_rst_left_word", w, 16'h0000);
    capture(132, w);
    check("post_rst_right_word", w, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
